// File: rtl/toy_sequencer.sv
// Multi-cycle sequencer for the toy accumulator CPU.
// It steps each instruction through FETCH, DECODE, MEM and WB.
// Datapath strobes are decoded combinationally from the current state, the
// opcode, the flags and mem_ready.
// Any memory wait that runs too long, or an illegal opcode, parks the core in
// HALT until reset.
module toy_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             carry,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             ir_load,
  output logic             wr_a,
  output logic             wr_t,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  // Wide enough to hold TIMEOUT-1, which is the last value reached before a timeout.
  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  instret_q;

  logic is_jmp, is_bcc, is_bne, is_read, is_write, is_wb_only, is_tat;
  logic timeout_hit;

  // Opcode classes. The opcode is held stable from DECODE until the next IR load,
  // so this classification is valid in DECODE, MEM and WB.
  always_comb begin
    is_jmp     = (opcode == 4'b0000);
    is_bcc     = (opcode == 4'b1010);
    is_bne     = (opcode == 4'b1011);
    is_tat     = (opcode == 4'b0101);
    is_wb_only = (opcode == 4'b0100) || is_tat;
    is_write   = (opcode == 4'b1101) || (opcode == 4'b1111);
    unique case (opcode)
      4'b0001, 4'b0010, 4'b0011, 4'b0110,
      4'b1000, 4'b1001, 4'b1100, 4'b1110: is_read = 1'b1;
      default:                            is_read = 1'b0;
    endcase
  end

  assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

  // Next-state logic and strobe decode.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    ir_load    = 1'b0;
    wr_a       = 1'b0;
    wr_t       = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        if (is_jmp) begin
          pc_load = 1'b1;
          state_d = S_FETCH;
        end else if (is_bcc || is_bne) begin
          // A branch is taken when its flag is clear. A branch that is not taken falls through.
          if (is_bcc ? !carry : !zero) pc_load = 1'b1;
          else                         pc_inc  = 1'b1;
          state_d = S_FETCH;
        end else if (is_read || is_write) begin
          state_d = S_MEM;
        end else if (is_wb_only) begin
          state_d = S_WB;
        end else begin
          // Only 0111 reaches this branch. It halts without a PC strobe.
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end

      S_MEM: begin
        dmem_rd = is_read;
        dmem_wr = !is_read;
        if (mem_ready) begin
          if (is_read) begin
            state_d = S_WB;
          end else begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        wr_t    = is_tat;
        wr_a    = !is_tat;
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // The wait counter measures a single stay in one state.
    if (state_d != state_q) wait_cnt_d = '0;
  end

  // State, error, wait-counter and retirement registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      err_q      <= ERR_NONE;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      instret_q  <= instret_q + CNT_W'(pc_inc | pc_load);
    end
  end

  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign err_code = err_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_toy_sequencer.sv
// Self-checking bench for toy_sequencer. The DUT is built with CNT_W=4 and TIMEOUT=16.
module tb_toy_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       carry = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic       imem_req, dmem_rd, dmem_wr, ir_load, wr_a, wr_t, pc_inc, pc_load, halted;
  logic [1:0] err_code;
  logic [2:0] state;
  logic [3:0] instret;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_instret = 4'h0;
  logic [1:0] exp_err = 2'b00;

  toy_sequencer #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry(carry), .zero(zero),
    .mem_ready(mem_ready), .imem_req(imem_req), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .ir_load(ir_load), .wr_a(wr_a), .wr_t(wr_t),
    .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
    .err_code(err_code), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [13:0] outv;
  assign outv = {imem_req, dmem_rd, dmem_wr, ir_load, wr_a, wr_t, pc_inc, pc_load,
                 halted, err_code, state};

  // Expected output vector. halted follows from the state being HALT.
  function automatic logic [13:0] mk(input logic [2:0] st, input logic im, rd, wr, ir,
                                     wa, wt, pi, pl, input logic [1:0] er);
    return {im, rd, wr, ir, wa, wt, pi, pl, (st == 3'd7), er, st};
  endfunction

  // Opcode class: 0 control, 1 read, 2 write, 3 wb-only, 4 illegal.
  function automatic int cls(input logic [3:0] op);
    case (op)
      4'h0, 4'hA, 4'hB:                         return 0;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hC, 4'hE: return 1;
      4'hD, 4'hF:                               return 2;
      4'h4, 4'h5:                               return 3;
      default:                                  return 4;
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // One clock cycle. The inputs are already set.
  // Outputs and instret are compared at the negedge, then time advances past the posedge.
  task automatic step(input logic [13:0] e, input string nm);
    @(negedge clk);
    check(nm, {2'b00, outv}, {2'b00, e});
    check({nm, "_instret"}, {12'h0, instret}, {12'h0, exp_instret});
    @(posedge clk); #1;
    if (e[7] | e[6]) exp_instret = exp_instret + 4'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 4'h0;
    exp_err = 2'b00;
  endtask

  // Reference model at the instruction level.
  // It expands one instruction into its expected per-cycle output trace.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
    logic dc, dz, pl;
    int k;
    k = cls(op);
    opcode = op;
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; carry = 1'($urandom); zero = 1'($urandom);
      step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, exp_err), "fetch_wait");
    end
    mem_ready = 1'b1;
    step(mk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, exp_err), "fetch");
    dc = 1'($urandom); dz = 1'($urandom);
    carry = dc; zero = dz; mem_ready = 1'($urandom);
    if (k == 0) begin
      pl = (op == 4'h0) ? 1'b1 : (op == 4'hA) ? !dc : !dz;
      step(mk(3'd1, 0, 0, 0, 0, 0, 0, !pl, pl, exp_err), "decode_br");
    end else if (k == 4) begin
      step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, exp_err), "decode_ill");
      exp_err = 2'b01;
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'($urandom);
        step(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, exp_err), "halt_ill");
      end
    end else begin
      step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, exp_err), "decode");
      if (k != 3) begin
        for (int i = 0; i < mw; i++) begin
          mem_ready = 1'b0; carry = 1'($urandom); zero = 1'($urandom);
          step(mk(3'd2, 0, k == 1, k == 2, 0, 0, 0, 0, 0, exp_err), "mem_wait");
        end
        mem_ready = 1'b1;
        step(mk(3'd2, 0, k == 1, k == 2, 0, 0, 0, k == 2, 0, exp_err), "mem");
      end
      if (k != 2) begin
        mem_ready = 1'($urandom); carry = 1'($urandom); zero = 1'($urandom);
        step(mk(3'd3, 0, 0, 0, 0, op != 4'h5, op == 4'h5, 1, 0, exp_err), "wb");
      end
    end
  endtask

  typedef struct {
    logic [3:0] op; logic c; logic z; int fw; int mw; int cyc;
    int n_rd; int n_wr; int n_wa; int n_wt; int n_pi; int n_pl; logic [1:0] err;
  } row_t;
  row_t rows[12];

  // Table-driven run. It answers memory waits by phase length and counts the strobes the DUT emits.
  task automatic run_row(input row_t r, input int idx);
    int cyc, phase, n_rd, n_wr, n_wa, n_wt, n_pi, n_pl;
    logic [2:0] prev;
    logic [3:0] base;
    bit left, done;
    cyc = 0; phase = 0; n_rd = 0; n_wr = 0; n_wa = 0; n_wt = 0; n_pi = 0; n_pl = 0;
    left = 0; done = 0; prev = state; base = instret;
    opcode = r.op; carry = r.c; zero = r.z;
    while (!done && cyc < 64) begin
      if (state != prev) phase = 0;
      prev = state;
      case (state)
        3'd0:    mem_ready = (phase >= r.fw);
        3'd2:    mem_ready = (phase >= r.mw);
        default: mem_ready = 1'b1;
      endcase
      @(negedge clk);
      n_rd += int'(dmem_rd); n_wr += int'(dmem_wr); n_wa += int'(wr_a);
      n_wt += int'(wr_t); n_pi += int'(pc_inc); n_pl += int'(pc_load);
      @(posedge clk); #1;
      cyc++; phase++;
      if (state != 3'd0) left = 1;
      if ((state == 3'd0 && left) || state == 3'd7) done = 1;
    end
    check($sformatf("row%0d_cycles", idx), 16'(cyc), 16'(r.cyc));
    check($sformatf("row%0d_strobes", idx),
          {4'(n_rd), 4'(n_wr), 4'(n_wa), 4'(n_wt)}, {4'(r.n_rd), 4'(r.n_wr), 4'(r.n_wa), 4'(r.n_wt)});
    check($sformatf("row%0d_pc", idx), {8'h0, 4'(n_pi), 4'(n_pl)}, {8'h0, 4'(r.n_pi), 4'(r.n_pl)});
    check($sformatf("row%0d_retire", idx), {12'h0, 4'(instret - base)}, 16'(r.n_pi + r.n_pl));
    check($sformatf("row%0d_err", idx), {14'h0, err_code}, {14'h0, r.err});
  endtask

  initial begin
    rows[0]  = '{4'h1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 1, 0, 2'b00};
    rows[1]  = '{4'hA, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 2'b00};
    rows[2]  = '{4'hA, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 2'b00};
    rows[3]  = '{4'hB, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0, 2'b00};
    rows[4]  = '{4'hB, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 2'b00};
    rows[5]  = '{4'h0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 2'b00};
    rows[6]  = '{4'hD, 0, 0, 0, 3, 6, 0, 4, 0, 0, 1, 0, 2'b00};
    rows[7]  = '{4'hF, 0, 0, 2, 0, 5, 0, 1, 0, 0, 1, 0, 2'b00};
    rows[8]  = '{4'h4, 0, 0, 0, 0, 3, 0, 0, 1, 0, 1, 0, 2'b00};
    rows[9]  = '{4'h5, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 2'b00};
    rows[10] = '{4'hE, 0, 0, 1, 2, 7, 3, 0, 1, 0, 1, 0, 2'b00};
    rows[11] = '{4'h7, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2'b01};

    // Check the reset state.
    do_reset();
    @(negedge clk);
    check("reset_state", {2'b00, outv}, {2'b00, mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00)});
    check("reset_instret", {12'h0, instret}, 16'h0);
    @(posedge clk); #1;
    do_reset();

    // Run the table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      run_row(rows[i], i);
      $display("row %0d op=%h done", i, rows[i].op);
      if (rows[i].err != 2'b00) do_reset();
    end

    // Hold mem_ready low for 16 FETCH cycles. The core must time out and halt.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00), "fetch_to");
    mem_ready = 1'b1;
    step(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10), "timeout_halt");
    step(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10), "timeout_hold");
    $display("fetch timeout sequence done");

    // Raise mem_ready on the 16th FETCH cycle. The fetch must complete normally.
    do_reset();
    opcode = 4'h4; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00), "fetch_15");
    mem_ready = 1'b1;
    step(mk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00), "fetch_16th");
    step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), "decode_after16");
    $display("fetch on last cycle sequence done");

    // Hold mem_ready low in MEM of a store. The core must time out and halt.
    do_reset();
    run_instr(4'h0, 0, 0);
    opcode = 4'hF; mem_ready = 1'b1;
    step(mk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00), "st_fetch");
    step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), "st_decode");
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step(mk(3'd2, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00), "mem_to");
    step(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10), "mem_timeout_halt");
    $display("mem timeout sequence done");

    // Execute an illegal opcode. The core must halt, hold there, and leave HALT only on reset.
    do_reset();
    run_instr(4'h7, 0, 0);
    check("ill_instret", {12'h0, instret}, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_instret = 4'h0; exp_err = 2'b00;
    check("rst_from_halt", {11'h0, err_code, state}, 16'h0);
    $display("illegal + reset sequence done");

    // Assert reset in the middle of MEM of a load. No wr_a may follow.
    opcode = 4'h1; mem_ready = 1'b1;
    step(mk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00), "lda_fetch");
    step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), "lda_decode");
    mem_ready = 1'b0; rst = 1'b1;
    step(mk(3'd2, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00), "lda_mem_rst");
    rst = 1'b0; mem_ready = 1'b1;
    step(mk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00), "after_mid_rst");
    $display("reset mid-MEM sequence done");

    // Run 16 JMPs. The 4-bit instret must wrap from 15 to 0.
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(4'h0, 0, 0);
    check("instret_15", {12'h0, instret}, 16'd15);
    run_instr(4'h0, 0, 0);
    check("instret_wrap", {12'h0, instret}, 16'd0);
    $display("instret wrap sequence done");

    // Run a random instruction stream against the model.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'h7) op = 4'h3;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("random stream of 150 instructions done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so that a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/toy_sequencer.md
Name: toy_sequencer

Overview:
Multi-cycle sequencer for the toy accumulator CPU. It steps each instruction through FETCH, DECODE, MEM and WB phases, and issues single-cycle strobes to the datapath: IR load, PC increment or load, A/T write, and data-memory read or write. Memory is handshaked with mem_ready and guarded by a timeout. An illegal opcode or a timeout parks the core in HALT until reset.

Parameters:
TIMEOUT, 16, max consecutive cycles waiting for mem_ready in FETCH or MEM before a timeout halt (>=2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
opcode  in  4  IR[7:4]; held stable by the datapath from DECODE until the next ir_load
carry  in  1  ALU carry flag, sampled in DECODE
zero  in  1  accumulator-zero flag, sampled in DECODE
mem_ready  in  1  memory completes the current request this cycle
imem_req  out  1  instruction fetch request (level)
dmem_rd  out  1  data read request (level)
dmem_wr  out  1  data write request (level)
ir_load  out  1  load IR (strobe)
wr_a  out  1  write accumulator (strobe)
wr_t  out  1  write T register (strobe)
pc_inc  out  1  PC <= PC+1 (strobe)
pc_load  out  1  PC <= vector (strobe)
halted  out  1  core parked in HALT
err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky
state  out  3  FETCH=0, DECODE=1, MEM=2, WB=3, HALT=7
instret  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst high at an edge): state=FETCH, wait_cnt=0, instret=0, halted=0, err_code=00. All strobes and dmem_* are 0. imem_req=1 because it is decoded from FETCH. rst overrides every transition, including from HALT and mid-MEM.
- Outputs are decoded combinationally from state, opcode, flags and mem_ready. There are no glitch requirements; the consumer samples at the edge.
- FETCH: imem_req=1. If mem_ready=1, ir_load=1 and next state is DECODE; otherwise stay.
- DECODE: one cycle, no memory request. Opcode classes:
  - 0000 JMP: pc_load=1 -> FETCH.
  - 1010 BCC: if carry=0, pc_load=1, else pc_inc=1 -> FETCH.
  - 1011 BNE: if zero=0, pc_load=1, else pc_inc=1 -> FETCH.
  - 0001, 0010, 0011, 0110, 1000, 1001, 1100, 1110 (read class) -> MEM.
  - 1101 STT, 1111 STA (write class) -> MEM.
  - 0100 ROR, 0101 TAT -> WB.
  - 0111 -> HALT with err_code=01. No PC strobe is issued.
- MEM: dmem_rd=1 for the read class, dmem_wr=1 for the write class; never both. When mem_ready=1:
  - read class -> WB.
  - write class -> pc_inc=1 -> FETCH.
- WB: one cycle, then FETCH.
  - wr_t=1 for TAT; wr_a=1 for all other opcodes reaching WB.
  - pc_inc=1 in the same cycle.
- Timeout: wait_cnt clears on every state change. In FETCH or MEM, each cycle with mem_ready=0 increments wait_cnt. If mem_ready=0 and wait_cnt==TIMEOUT-1, the next state is HALT with err_code=10. mem_ready=1 on any cycle, including the TIMEOUT-th, completes normally.
- HALT: halted=1 and all strobes and requests are 0. The only exit is rst; err_code holds.
- Retirement: instret increments on every cycle where pc_inc or pc_load is 1. pc_inc and pc_load are never 1 together.
- Latency (mem_ready immediate):
  - JMP, BCC, BNE: 2 cycles.
  - ROR, TAT: 3 cycles.
  - Stores: 3 cycles.
  - Reads and ALU ops: 4 cycles.
  - Each mem_ready=0 cycle adds 1.
- Flags are sampled only in DECODE; changes during MEM or WB are ignored.

Test Plan:
- Reset then mem_ready=1 always, opcode=0001 -> states 0,1,2,3,0. dmem_rd high in state 2; wr_a and pc_inc high in state 3; instret=1 after 4 cycles.
- opcode=1010 with carry=0 -> pc_load in DECODE, 2-cycle instruction. Repeat with carry=1 -> pc_inc instead. opcode=1011 with zero=1 -> pc_inc.
- opcode=1101, mem_ready low for 3 MEM cycles then high -> dmem_wr high for 4 cycles, never dmem_rd; pc_inc on the 4th; total 6 cycles.
- TIMEOUT=16, mem_ready held 0 in FETCH -> HALT entered after exactly 16 FETCH cycles; err_code=10, halted=1, imem_req=0. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no error.
- opcode=0111 -> HALT, err_code=01, no pc_inc/pc_load, instret unchanged. rst asserted -> state=0, err_code=00 after one edge.
- CNT_W=4: run 16 JMPs -> instret wraps 15->0. Asserting rst mid-MEM of an LDA -> no wr_a, state=FETCH next cycle.
